// File: rtl/pad_cond_pkg.sv
// rtl/pad_cond_pkg.sv - shared constants for the pad input conditioner
package pad_cond_pkg;

    // Channel assignment of the conditioned pad inputs
    localparam int CH_SCL  = 0;
    localparam int CH_SDA  = 1;
    localparam int CH_RXD  = 2;
    localparam int CH_DRDY = 3;
    localparam int CH_MISO = 4;

    localparam int              DEF_NUM_CH     = 5;
    localparam int              DEF_FILT_CNT_W = 4;
    // SCL, SDA, RXD and DRDY idle high; MISO idles low
    localparam logic [4:0]      DEF_RST_VAL    = 5'b01111;

endpackage

// File: rtl/pad_sync_filter.sv
// rtl/pad_sync_filter.sv - one channel: synchronizer, glitch filter, edge pulses
module pad_sync_filter #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CNT_W  = 4,
    parameter int   FILT_LEN    = 3,
    parameter logic RST_BIT     = 1'b0
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_PAD,
    output logic o_IN,
    output logic o_RISE,
    output logic o_FALL,
    output logic o_UPD
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILT_CNT_W-1:0]  r_cnt;
    logic                   r_in;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic                   w_diff;
    logic                   w_upd;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_diff = (w_s != r_in);
    // The accepted level flips on the edge where the differing level has been seen FILT_LEN times
    assign w_upd  = w_diff && (r_cnt == FILT_CNT_W'(FILT_LEN - 1));

    // Metastability synchronizer chain; reset preloads the idle level so no edge is seen after reset
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_sync <= {SYNC_STAGES{RST_BIT}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_PAD};
        end
    end

    // Stability counter: any reversion to the accepted level restarts the count
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_cnt <= '0;
            r_in  <= RST_BIT;
        end else if (!w_diff) begin
            r_cnt <= '0;
        end else if (w_upd) begin
            r_cnt <= '0;
            r_in  <= w_s;
        end else begin
            r_cnt <= r_cnt + FILT_CNT_W'(1);
        end
    end

    // Edge pulses registered alongside the level so they coincide with its first new cycle
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_upd &&  w_s;
            r_fall <= w_upd && !w_s;
        end
    end

    assign o_IN   = r_in;
    assign o_RISE = r_rise;
    assign o_FALL = r_fall;
    assign o_UPD  = w_upd;

endmodule

// File: rtl/pad_input_conditioner.sv
// rtl/pad_input_conditioner.sv - pad input conditioning with I2C and DRDY event detection
module pad_input_conditioner
    import pad_cond_pkg::*;
#(
    parameter int                NUM_CH      = DEF_NUM_CH,
    parameter int                SYNC_STAGES = 2,
    parameter int                FILT_CNT_W  = DEF_FILT_CNT_W,
    parameter int                FILT_LEN    = 3,
    parameter logic [NUM_CH-1:0] RST_VAL     = DEF_RST_VAL
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic [NUM_CH-1:0] i_PAD_IN,
    output logic [NUM_CH-1:0] o_IN,
    output logic [NUM_CH-1:0] o_RISE,
    output logic [NUM_CH-1:0] o_FALL,
    output logic              o_I2C_START,
    output logic              o_I2C_STOP,
    output logic              o_DRDY_EVT,
    output logic              o_DRDY_OVR,
    input  logic              i_DRDY_ACK
);

    logic [NUM_CH-1:0] w_upd;
    logic              w_sda_fall;
    logic              w_sda_rise;
    logic              w_scl_steady_hi;
    logic              w_drdy_fall;
    logic              r_start;
    logic              r_stop;
    logic              r_evt;
    logic              r_ovr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pad_sync_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CNT_W  (FILT_CNT_W),
            .FILT_LEN    (FILT_LEN),
            .RST_BIT     (RST_VAL[g])
        ) u_ch (
            .i_CLK  (i_CLK),
            .i_RST  (i_RST),
            .i_PAD  (i_PAD_IN[g]),
            .o_IN   (o_IN[g]),
            .o_RISE (o_RISE[g]),
            .o_FALL (o_FALL[g]),
            .o_UPD  (w_upd[g])
        );
    end

    // o_IN still holds the pre-update level here, so it gives the direction of each update
    assign w_sda_fall      = w_upd[CH_SDA]  &&  o_IN[CH_SDA];
    assign w_sda_rise      = w_upd[CH_SDA]  && !o_IN[CH_SDA];
    assign w_scl_steady_hi = o_IN[CH_SCL]   && !w_upd[CH_SCL];
    assign w_drdy_fall     = w_upd[CH_DRDY] &&  o_IN[CH_DRDY];

    // I2C START/STOP, suppressed when SCL moves on the same edge
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_start <= 1'b0;
            r_stop  <= 1'b0;
        end else begin
            r_start <= w_sda_fall && w_scl_steady_hi;
            r_stop  <= w_sda_rise && w_scl_steady_hi;
        end
    end

    // Sticky DRDY event and overrun; a new fall together with ACK leaves only the new event pending
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_evt <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            r_evt <= w_drdy_fall || (r_evt && !i_DRDY_ACK);
            r_ovr <= !i_DRDY_ACK && (r_ovr || (r_evt && w_drdy_fall));
        end
    end

    assign o_I2C_START = r_start;
    assign o_I2C_STOP  = r_stop;
    assign o_DRDY_EVT  = r_evt;
    assign o_DRDY_OVR  = r_ovr;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// tb/tb_pad_input_conditioner.sv - self-checking bench for pad_input_conditioner
module tb_pad_input_conditioner;

    localparam int         SYNC = 2;
    localparam int         FLEN = 3;
    localparam logic [4:0] RSTV = 5'b01111;

    logic       clk;
    logic       rst;
    logic [4:0] pad;
    logic       ack;
    logic [4:0] o_in;
    logic [4:0] o_rise;
    logic [4:0] o_fall;
    logic       o_start;
    logic       o_stop;
    logic       o_evt;
    logic       o_ovr;

    int n_checks = 0;
    int n_fail   = 0;

    pad_input_conditioner dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_PAD_IN    (pad),
        .o_IN        (o_in),
        .o_RISE      (o_rise),
        .o_FALL      (o_fall),
        .o_I2C_START (o_start),
        .o_I2C_STOP  (o_stop),
        .o_DRDY_EVT  (o_evt),
        .o_DRDY_OVR  (o_ovr),
        .i_DRDY_ACK  (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: pad delayed by the synchronizer depth, a level is accepted
    // once the last FLEN delayed samples (since reset) all disagree with the current level.
    logic [4:0]      m_dly [SYNC];
    logic [FLEN-1:0] m_hist [5];
    int              m_nv [5];
    logic [4:0]      m_in, m_rise, m_fall, m_s, m_nin;
    logic            m_start, m_stop, m_evt, m_ovr;
    bit              m_started = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < SYNC; k++) m_dly[k] = RSTV;
                for (int c = 0; c < 5; c++) begin
                    m_nv[c]   = 0;
                    m_hist[c] = '0;
                end
                m_in = RSTV; m_rise = '0; m_fall = '0;
                m_start = 0; m_stop = 0; m_evt = 0; m_ovr = 0;
            end else begin
                m_s = m_dly[SYNC-1];
                for (int k = SYNC-1; k > 0; k--) m_dly[k] = m_dly[k-1];
                m_dly[0] = pad;
                m_nin = m_in;
                for (int c = 0; c < 5; c++) begin
                    m_hist[c] = {m_hist[c][FLEN-2:0], m_s[c]};
                    if (m_nv[c] < FLEN) m_nv[c]++;
                    if (m_nv[c] == FLEN && m_hist[c] == {FLEN{~m_in[c]}}) m_nin[c] = ~m_in[c];
                end
                m_rise  = m_nin & ~m_in;
                m_fall  = ~m_nin & m_in;
                m_start = m_fall[1] && m_in[0] && (m_nin[0] == m_in[0]);
                m_stop  = m_rise[1] && m_in[0] && (m_nin[0] == m_in[0]);
                if (m_fall[3]) begin
                    if (ack)        m_ovr = 0;
                    else if (m_evt) m_ovr = 1;
                    m_evt = 1;
                end else if (ack) begin
                    m_evt = 0;
                    m_ovr = 0;
                end
                m_in = m_nin;
            end
            m_started = 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                chk("o_IN",        32'(o_in),    32'(m_in));
                chk("o_RISE",      32'(o_rise),  32'(m_rise));
                chk("o_FALL",      32'(o_fall),  32'(m_fall));
                chk("o_I2C_START", 32'(o_start), 32'(m_start));
                chk("o_I2C_STOP",  32'(o_stop),  32'(m_stop));
                chk("o_DRDY_EVT",  32'(o_evt),   32'(m_evt));
                chk("o_DRDY_OVR",  32'(o_ovr),   32'(m_ovr));
            end
        end
    end

    initial begin
        rst = 1'b1;
        pad = RSTV;
        ack = 1'b0;
        step(3);
        chk("reset_in",    32'(o_in), 32'h0f);
        chk("reset_flags", 32'({o_rise, o_fall, o_start, o_stop, o_evt, o_ovr}), 32'h0);
        rst = 1'b0;
        step(20);
        chk("idle_in",     32'(o_in), 32'h0f);
        chk("idle_pulses", 32'({o_rise, o_fall, o_start, o_stop, o_evt, o_ovr}), 32'h0);

        // RXD step low: five-cycle latency, single FALL pulse
        pad[2] = 1'b0;
        step(4);
        chk("rxd_before_latency", 32'(o_in[2]), 32'd1);
        step(1);
        chk("rxd_after_latency",  32'(o_in[2]), 32'd0);
        chk("rxd_fall_pulse",     32'(o_fall[2]), 32'd1);
        step(1);
        chk("rxd_fall_one_cycle", 32'(o_fall[2]), 32'd0);
        pad[2] = 1'b1;
        step(8);

        // 2-cycle glitch rejected, 3-cycle pulse passes
        pad[2] = 1'b0;
        step(2);
        pad[2] = 1'b1;
        step(8);
        chk("glitch_rejected", 32'(o_in[2]), 32'd1);
        pad[2] = 1'b0;
        step(3);
        pad[2] = 1'b1;
        step(2);
        chk("pulse_low",  32'({o_in[2], o_fall[2]}), 32'b01);
        step(3);
        chk("pulse_high", 32'({o_in[2], o_rise[2]}), 32'b11);
        step(4);

        // I2C START then STOP with SCL held high
        pad[1] = 1'b0;
        step(5);
        chk("i2c_start", 32'({o_start, o_fall[1]}), 32'b11);
        step(1);
        chk("i2c_start_one_cycle", 32'(o_start), 32'd0);
        step(4);
        pad[1] = 1'b1;
        step(5);
        chk("i2c_stop", 32'({o_stop, o_rise[1]}), 32'b11);
        step(5);
        // SCL and SDA stepped together: no event
        pad[1:0] = 2'b00;
        step(5);
        chk("i2c_same_edge_fall", 32'({o_start, o_fall[1], o_fall[0]}), 32'b011);
        step(5);
        pad[1:0] = 2'b11;
        step(5);
        chk("i2c_same_edge_rise", 32'({o_stop, o_rise[1], o_rise[0]}), 32'b011);
        step(3);

        // DRDY: event, overrun, acknowledge, coincident ACK and fall
        pad[3] = 1'b0;
        step(5);
        chk("drdy_evt", 32'({o_evt, o_ovr, o_fall[3]}), 32'b101);
        pad[3] = 1'b1;
        step(8);
        pad[3] = 1'b0;
        step(5);
        chk("drdy_ovr", 32'({o_evt, o_ovr}), 32'b11);
        pad[3] = 1'b1;
        step(8);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("drdy_ack_clear", 32'({o_evt, o_ovr}), 32'b00);
        step(2);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("drdy_ack_idle", 32'({o_evt, o_ovr}), 32'b00);
        pad[3] = 1'b0;
        step(5);
        chk("drdy_evt_again", 32'(o_evt), 32'd1);
        pad[3] = 1'b1;
        step(8);
        pad[3] = 1'b0;
        step(4);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("drdy_ack_with_fall", 32'({o_evt, o_ovr, o_fall[3]}), 32'b101);
        pad[3] = 1'b1;
        step(8);

        // Reset while the RXD count is at 2: full filter length needed again
        pad[2] = 1'b0;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_mid_in",   32'({o_in[2], o_fall[2]}), 32'b10);
        chk("rst_mid_evt",  32'({o_evt, o_ovr}), 32'b00);
        step(4);
        chk("rst_mid_hold", 32'(o_in[2]), 32'd1);
        step(1);
        chk("rst_mid_accept", 32'({o_in[2], o_fall[2]}), 32'b01);
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
